// File: rtl/neopixel_pkg.sv
// Shared NeoPixel timing constants (27 MHz i_clk) and frame controller types.
package neopixel_pkg;

  localparam int unsigned T0H_CYCLES         = 10;
  localparam int unsigned T0L_CYCLES         = 22;
  localparam int unsigned T1H_CYCLES         = 20;
  localparam int unsigned T1L_CYCLES         = 12;
  localparam int unsigned BIT_CYCLES         = 32;
  localparam int unsigned TRESET_CYCLES      = 2200;
  localparam int unsigned TX_MARGIN_CYCLES   = 4;
  localparam int unsigned DEFAULT_NUM_PIXELS = 8;

  function automatic int unsigned tx_frame_cycles(input int unsigned num_pixels);
    return num_pixels * 24 * BIT_CYCLES + TRESET_CYCLES + TX_MARGIN_CYCLES;
  endfunction

  localparam int unsigned DEFAULT_TX_FRAME_CYCLES = tx_frame_cycles(DEFAULT_NUM_PIXELS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/neopixel_frame_ctrl_if.sv
// CPU-side pixel write and frame request bus of the frame controller.
interface neopixel_frame_ctrl_if;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [23:0] wr_data;
  logic        commit;
  logic        kick;

  modport master (output wr_en, wr_addr, wr_data, commit, kick);
  modport slave  (input  wr_en, wr_addr, wr_data, commit, kick);
endinterface

// File: rtl/neopixel_pixel_bank.sv
// Two GRB pixel banks: synchronous write into one bank, asynchronous read from the other.
module neopixel_pixel_bank
  import neopixel_pkg::*;
#(
  parameter int unsigned NUM_PIXELS = DEFAULT_NUM_PIXELS,
  parameter int unsigned AW         = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [7:0]    wr_addr,
  input  logic [23:0]   wr_data,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic [23:0]   rd_data
);

  logic [23:0] mem [2][NUM_PIXELS];

  // Out-of-range addresses are dropped rather than aliased onto low pixels.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < 9'(NUM_PIXELS)))
      mem[wr_bank][wr_addr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/neopixel_frame_ctrl.sv
// Frame scheduler for neopixel_tx: bank swap at frame boundaries, refresh timer, read look-ahead.
module neopixel_frame_ctrl
  import neopixel_pkg::*;
#(
  parameter int unsigned NUM_PIXELS      = DEFAULT_NUM_PIXELS,
  parameter int unsigned FRAME_PERIOD    = 450000,
  parameter int unsigned TX_FRAME_CYCLES = tx_frame_cycles(NUM_PIXELS)
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  neopixel_frame_ctrl_if.slave       cpu,
  input  logic                       i_auto_en,
  output logic                       o_tx_start,
  input  logic [7:0]                 i_tx_addr,
  output logic [23:0]                o_tx_data,
  output logic                       o_busy,
  output logic                       o_swap_pending,
  output logic [15:0]                o_frame_count
);

  localparam int unsigned AW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int unsigned TW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam int unsigned CW = (TX_FRAME_CYCLES > 1) ? $clog2(TX_FRAME_CYCLES) : 1;

  ctrl_state_t   state, next_state;
  logic          go;
  logic          front_sel;
  logic          swap_pending;
  logic          refresh_req;
  logic          timer_wrap;
  logic [TW-1:0] timer;
  logic [CW-1:0] busy_cnt;
  logic [8:0]    rd_idx;
  logic [23:0]   bank_data;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= S_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    go         = 1'b0;
    case (state)
      S_IDLE: begin
        if (refresh_req || swap_pending) begin
          next_state = S_START;
          go         = 1'b1;
        end
      end
      S_START: next_state = S_BUSY;
      S_BUSY:  if (busy_cnt == '0) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  assign timer_wrap = i_auto_en && (timer == TW'(FRAME_PERIOD - 1));

  // Requests landing on the service edge are absorbed into the frame being started.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      timer         <= '0;
      refresh_req   <= 1'b0;
      swap_pending  <= 1'b0;
      front_sel     <= 1'b0;
      o_tx_start    <= 1'b0;
      o_frame_count <= '0;
      busy_cnt      <= '0;
    end else begin
      if (!i_auto_en || timer_wrap) timer <= '0;
      else                          timer <= timer + 1'b1;

      if (go)                          refresh_req <= 1'b0;
      else if (cpu.kick || timer_wrap) refresh_req <= 1'b1;

      if (go)              swap_pending <= 1'b0;
      else if (cpu.commit) swap_pending <= 1'b1;

      if (go && swap_pending) front_sel <= ~front_sel;

      o_tx_start <= go;
      if (go) o_frame_count <= o_frame_count + 16'd1;

      if (state == S_START)                       busy_cnt <= CW'(TX_FRAME_CYCLES - 1);
      else if (state == S_BUSY && busy_cnt != '0) busy_cnt <= busy_cnt - 1'b1;
    end
  end

  // The transmitter latches pixel N+1 while still presenting address N.
  assign rd_idx    = (state == S_BUSY) ? ({1'b0, i_tx_addr} + 9'd1) : '0;
  assign o_tx_data = (rd_idx < 9'(NUM_PIXELS)) ? bank_data : '0;

  assign o_busy         = (state != S_IDLE);
  assign o_swap_pending = swap_pending;

  neopixel_pixel_bank #(
    .NUM_PIXELS (NUM_PIXELS),
    .AW         (AW)
  ) u_bank (
    .clk     (i_clk),
    .wr_en   (cpu.wr_en),
    .wr_bank (~front_sel),
    .wr_addr (cpu.wr_addr),
    .wr_data (cpu.wr_data),
    .rd_bank (front_sel),
    .rd_addr (rd_idx[AW-1:0]),
    .rd_data (bank_data)
  );

endmodule

// File: tb/tb_neopixel_frame_ctrl.sv
// Directed scoreboard bench for neopixel_frame_ctrl with a reference pixel-bank model.
module tb_neopixel_frame_ctrl;
  import neopixel_pkg::*;

  localparam int unsigned NP  = 8;
  localparam int unsigned FP  = 10000;
  localparam int unsigned TXC = 2000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        auto_en = 1'b0;
  logic [7:0]  tx_addr = '0;
  logic        tx_start;
  logic [23:0] tx_data;
  logic        busy;
  logic        swap_pending;
  logic [15:0] frame_count;

  neopixel_frame_ctrl_if cpu_bus ();

  neopixel_frame_ctrl #(
    .NUM_PIXELS      (NP),
    .FRAME_PERIOD    (FP),
    .TX_FRAME_CYCLES (TXC)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .cpu            (cpu_bus.slave),
    .i_auto_en      (auto_en),
    .o_tx_start     (tx_start),
    .i_tx_addr      (tx_addr),
    .o_tx_data      (tx_data),
    .o_busy         (busy),
    .o_swap_pending (swap_pending),
    .o_frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [23:0] mdl [2][NP];
  logic        mfront = 1'b0;
  logic [15:0] mcount = '0;
  logic [23:0] data_q [$];
  logic [15:0] fc_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input logic [7:0] addr, input logic [23:0] data);
    cpu_bus.wr_en   = 1'b1;
    cpu_bus.wr_addr = addr;
    cpu_bus.wr_data = data;
    if (addr < NP) mdl[!mfront][addr[2:0]] = data;
    tick();
    cpu_bus.wr_en = 1'b0;
  endtask

  task automatic pulse_commit();
    cpu_bus.commit = 1'b1;
    tick();
    cpu_bus.commit = 1'b0;
  endtask

  task automatic pulse_kick();
    cpu_bus.kick = 1'b1;
    tick();
    cpu_bus.kick = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [7:0] addr, input bit in_busy);
    logic [8:0] idx;
    tx_addr = addr;
    idx = in_busy ? ({1'b0, addr} + 9'd1) : 9'd0;
    data_q.push_back((idx < NP) ? mdl[mfront][idx[2:0]] : 24'h0);
    #1;
    check(tag, 32'(tx_data), 32'(data_q.pop_front()));
  endtask

  task automatic expect_frame(input bit swap);
    mcount++;
    fc_q.push_back(mcount);
    if (swap) mfront = !mfront;
  endtask

  task automatic wait_start(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (!tx_start && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_start"}, 32'(tx_start), 32'd1);
    if (tx_start && fc_q.size() > 0)
      check({tag, "_count"}, 32'(frame_count), 32'(fc_q.pop_front()));
  endtask

  task automatic wait_idle(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int unsigned t0;
    int unsigned starts;
    int unsigned st [4];

    cpu_bus.wr_en   = 1'b0;
    cpu_bus.wr_addr = '0;
    cpu_bus.wr_data = '0;
    cpu_bus.commit  = 1'b0;
    cpu_bus.kick    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_swap", 32'(swap_pending), 0);
    check("rst_count", 32'(frame_count), 0);
    reset = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 0);

    // Commit a full frame, then walk the transmitter read contract.
    for (int i = 0; i < 8; i++) write_px(8'(i), 24'(i + 1));
    pulse_commit();
    check("commit_pending", 32'(swap_pending), 1);
    check("commit_no_start", 32'(tx_start), 0);
    expect_frame(1'b1);
    tick();
    wait_start("t1", 0);
    check("t1_pending_clr", 32'(swap_pending), 0);
    t0 = cyc;
    read_check("start_a7", 8'd7, 1'b0);
    tick();
    check("t1_start_width", 32'(tx_start), 0);
    read_check("busy_a3", 8'd3, 1'b1);
    read_check("busy_a7", 8'd7, 1'b1);
    for (int i = 0; i < 7; i++) read_check("busy_stream", 8'(i), 1'b1);
    wait_idle("t1", TXC + 10);
    check("t1_busy_len", cyc - t0, TXC + 1);
    read_check("idle_a7", 8'd7, 1'b0);
    repeat (5) tick();
    check("t1_no_restart", 32'(frame_count), 32'(mcount));

    // Kick-started frame; commit, kick and a second commit arrive mid-frame.
    for (int i = 0; i < 8; i++) write_px(8'(i), 24'h100 + 24'(i));
    pulse_kick();
    expect_frame(1'b0);
    wait_start("t3a", 4);
    repeat (100) tick();
    pulse_commit();
    check("t3_pending", 32'(swap_pending), 1);
    pulse_kick();
    repeat (10) tick();
    pulse_commit();
    wait_idle("t3", TXC + 10);
    check("t3_gap_no_start", 32'(tx_start), 0);
    expect_frame(1'b1);
    tick();
    wait_start("t3b", 0);
    read_check("t3_front0", 8'd2, 1'b0);
    wait_idle("t3b", TXC + 10);
    starts = 0;
    repeat (2 * TXC) begin
      tick();
      if (tx_start) starts++;
    end
    check("t3_single_start", starts, 0);
    check("t3_count", 32'(frame_count), 32'(mcount));

    // Out-of-range writes ignored; a write on the swap edge joins the new frame.
    write_px(8'd201, 24'hABCDEF);
    write_px(8'd200, 24'h123456);
    pulse_commit();
    check("t4_pending", 32'(swap_pending), 1);
    write_px(8'd0, 24'h5A5A5A);
    expect_frame(1'b1);
    wait_start("t4", 0);
    read_check("t4_front0", 8'd5, 1'b0);
    tick();
    read_check("t4_pix1", 8'd0, 1'b1);
    read_check("t4_pix2", 8'd1, 1'b1);
    wait_idle("t4", TXC + 10);

    // Periodic refresh: three starts exactly one period apart, no swap.
    starts = 0;
    auto_en = 1'b1;
    repeat (35000) begin
      tick();
      if (tx_start) begin
        if (starts < 4) st[starts] = cyc;
        starts++;
        mcount++;
        check("auto_count", 32'(frame_count), 32'(mcount));
      end
    end
    auto_en = 1'b0;
    check("auto_starts", starts, 3);
    check("auto_gap1", st[1] - st[0], FP);
    check("auto_gap2", st[2] - st[1], FP);
    wait_idle("auto", TXC + 10);
    check("auto_no_swap", 32'(swap_pending), 0);
    read_check("auto_front0", 8'd3, 1'b0);

    // Asynchronous reset in the middle of a frame with a swap pending.
    pulse_kick();
    expect_frame(1'b0);
    wait_start("t6", 4);
    repeat (500) tick();
    pulse_commit();
    check("t6_pending", 32'(swap_pending), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_tx_start", 32'(tx_start), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_swap", 32'(swap_pending), 0);
    check("mid_rst_count", 32'(frame_count), 0);
    mfront = 1'b0;
    mcount = '0;
    tick();
    reset = 1'b0;
    starts = 0;
    repeat (20000) begin
      tick();
      if (tx_start) starts++;
    end
    check("rst_no_start", starts, 0);
    check("rst_idle_busy", 32'(busy), 0);
    read_check("rst_front0", 8'd7, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/neopixel_frame_ctrl.md
Name: neopixel_frame_ctrl

Overview:
Frame scheduler and double-buffered pixel store for the NeoPixel transmitter (neopixel_tx).
- The CPU side writes 24-bit GRB pixels into a back bank and commits.
- The controller swaps banks only at frame boundaries and pulses the transmitter start, either periodically or on demand.
- It serves the transmitter's pixel reads from the front bank.
- It tracks transmitter busy time internally, because the transmitter exports no busy/done signal.

Parameters:
NUM_PIXELS, 8, number of pixels per frame (1..256)
FRAME_PERIOD, 450000, auto-refresh period in i_clk cycles (60 Hz at 27 MHz)
TX_FRAME_CYCLES, 8348, cycles reserved per transmission (NUM_PIXELS*24*32 + 2200 reset + 4 margin)

Ports:
i_clk  in  1  system clock, 27 MHz
i_reset  in  1  asynchronous, active-high reset
i_wr_en  in  1  pixel write strobe (CPU side)
i_wr_addr  in  8  pixel index for write
i_wr_data  in  24  GRB pixel value
i_commit  in  1  request bank swap plus transmission of the back bank
i_kick  in  1  request one transmission of the current front bank
i_auto_en  in  1  enable periodic refresh timer
o_tx_start  out  1  one-cycle start pulse to transmitter
i_tx_addr  in  8  transmitter read address (its o_mem_addr)
o_tx_data  out  24  pixel data to transmitter (its i_mem_data)
o_busy  out  1  high while state != S_IDLE
o_swap_pending  out  1  commit accepted, swap not yet performed
o_frame_count  out  16  number of transmissions started, wraps at 65535→0

Behaviour:
- Reset (async) values:
  - o_tx_start=0, o_busy=0, o_swap_pending=0, o_frame_count=0.
  - Internal: state=S_IDLE, front_sel=0, refresh_req=0, timers=0.
  - Bank contents are not reset (undefined until written).
- Writes:
  - Synchronous write to bank[~front_sel][i_wr_addr] when i_wr_en.
  - Writes with i_wr_addr >= NUM_PIXELS are ignored.
  - Writes are accepted in every state.
- Refresh timer:
  - Counts while i_auto_en=1; at FRAME_PERIOD-1 it wraps to 0 and sets refresh_req.
  - i_auto_en=0 clears the timer to 0.
  - i_kick sets refresh_req.
  - Multiple requests before service coalesce into one.
- Commit: i_commit sets swap_pending; repeated commits while pending have no further effect.
- FSM states: S_IDLE, S_START, S_BUSY.
  - S_IDLE→S_START when refresh_req or swap_pending.
    - On that edge: if swap_pending, toggle front_sel and clear swap_pending.
    - refresh_req is cleared.
    - A request arriving in the same cycle is also absorbed.
  - S_START lasts exactly 1 cycle.
    - o_tx_start=1 (registered) and o_frame_count increments.
    - Next state is S_BUSY.
  - S_BUSY lasts TX_FRAME_CYCLES cycles (down-counter), then → S_IDLE.
  - Requests arriving in S_START/S_BUSY are held and serviced on return to S_IDLE, giving at least 1 idle cycle between frames.
- Read contract (combinational, from front bank):
  - In S_IDLE and S_START, o_tx_data = front[0], independent of i_tx_addr, because the transmitter latches data on the start cycle.
  - In S_BUSY, o_tx_data = front[i_tx_addr+1], because the transmitter latches the next pixel while its address still shows the current pixel.
  - o_tx_data = 0 when i_tx_addr+1 >= NUM_PIXELS.
- Boundary cases:
  - A write in the same cycle as the swap edge lands in the old back bank, which becomes front. That write is therefore included in the frame about to start.
  - After a swap, the new back bank holds the pixels shown two commits ago. There is no copy; software rewrites the full frame.
  - Reset mid-frame aborts immediately: o_tx_start=0, state=S_IDLE. The transmitter shares i_reset.

Decomposition:
- Shared package neopixel_pkg holds:
  - NeoPixel timing constants (T0H/T0L/T1H/T1L/TRESET cycles, 27 MHz), shared with neopixel_tx.
  - Default NUM_PIXELS.
  - Derived TX_FRAME_CYCLES.
  - Controller state encodings.
- One sub-module, neopixel_pixel_bank: two banks of NUM_PIXELS×24 with a synchronous write port into the selected back bank and an asynchronous read port from the front bank.
- FSM, timer and address look-ahead stay in neopixel_frame_ctrl.

Test Plan:
- Reset, write pixels 0..7 = 0x000001..0x000008, pulse i_commit. Expect:
  - o_swap_pending high 1 cycle, then o_tx_start pulse 1 cycle.
  - o_frame_count=1; o_busy high for TX_FRAME_CYCLES+1 cycles.
  - Decoded neopixel_tx serial stream equals 0x000001..0x000008 in order.
- Idle, i_tx_addr=7: o_tx_data=front[0]. In S_BUSY, i_tx_addr=3 gives front[4], and i_tx_addr=7 gives 0.
- i_auto_en=1 with FRAME_PERIOD=10000 for 35000 cycles: exactly 3 o_tx_start pulses, spaced 10000 cycles, and no swap.
- i_commit and i_kick asserted mid-S_BUSY, plus a second i_commit: after busy ends, exactly one start and one swap. o_frame_count is +1, not +2.
- Write addr 200 (NUM_PIXELS=8): no bank change. Write addr 0 on the IDLE→START swap edge: the transmitted pixel 0 is the new value.
- Assert i_reset at busy cycle 500: all outputs 0 immediately. After release with no requests, no o_tx_start for 20000 cycles.
